// File: rtl/mem_access_ctrl.sv
// Byte-serial load/store sequencer for a byte-wide synchronous RAM.
// Big-endian byte order, one RAM byte per cycle, single-cycle response.
module mem_access_ctrl #(
   parameter int ADDR_W      = 6,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_length,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wbyte,
   input  logic [7:0]        mem_rbyte
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DRAIN,
      RESP
   } state_t;

   state_t state_q, state_d;
   logic [1:0] k_q, k_d;
   logic [1:0] last_k;

   logic              w_q;
   logic [1:0]        len_q;
   logic              sgn_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wd_q;
   logic [31:0]       asm_q;
   logic              err_q;

   logic        accept;
   logic        hi_bits;
   logic        misalign;
   logic        req_err;
   logic [31:0] wd_just;
   logic [31:0] result;

   assign req_ready = (state_q == IDLE) && !reset;
   assign accept    = req_valid && req_ready;

   // Upper address bits must be zero; RAM only decodes ADDR_W bits.
   assign hi_bits  = (req_addr >> ADDR_W) != 32'd0;
   assign misalign = ALIGN_CHECK &&
                     (((req_length == 2'b10) && req_addr[0]) ||
                      ((req_length == 2'b11) && (req_addr[1:0] != 2'b00)));
   assign req_err  = (req_length == 2'b00) || hi_bits || misalign;

   // Left-justify store data so byte k is always the top byte after k shifts.
   always_comb begin
      wd_just = req_wdata;
      unique case (req_length)
         2'b01:   wd_just = {req_wdata[7:0], 24'h0};
         2'b10:   wd_just = {req_wdata[15:0], 16'h0};
         default: wd_just = req_wdata;
      endcase
   end

   // Final counter value for the captured access length.
   always_comb begin
      last_k = 2'd0;
      unique case (len_q)
         2'b10:   last_k = 2'd1;
         2'b11:   last_k = 2'd3;
         default: last_k = 2'd0;
      endcase
   end

   // Extend the assembled load value to 32 bits.
   always_comb begin
      result = asm_q;
      unique case (len_q)
         2'b01:   result = {{24{sgn_q & asm_q[7]}}, asm_q[7:0]};
         2'b10:   result = {{16{sgn_q & asm_q[15]}}, asm_q[15:0]};
         default: result = asm_q;
      endcase
   end

   // State register and byte counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= 2'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // Next-state logic and outputs decoded from registered state only.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wbyte  = 8'h00;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'h0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = req_err ? RESP : ACCESS;
               k_d     = 2'd0;
            end
         end
         ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = w_q;
            mem_addr  = addr_q + ADDR_W'(k_q);
            mem_wbyte = w_q ? wd_q[31:24] : 8'h00;
            if (k_q == last_k) begin
               state_d = w_q ? RESP : DRAIN;
               k_d     = 2'd0;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         DRAIN: begin
            state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (err_q || w_q) ? 32'h0 : result;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request capture, store-data shifting and load assembly.
   always_ff @(posedge clock) begin
      if (reset) begin
         w_q    <= 1'b0;
         len_q  <= 2'b00;
         sgn_q  <= 1'b0;
         addr_q <= '0;
         wd_q   <= 32'h0;
         asm_q  <= 32'h0;
         err_q  <= 1'b0;
      end else if (accept) begin
         w_q    <= req_write;
         len_q  <= req_length;
         sgn_q  <= req_signed;
         addr_q <= req_addr[ADDR_W-1:0];
         wd_q   <= wd_just;
         asm_q  <= 32'h0;
         err_q  <= req_err;
      end else begin
         if ((state_q == ACCESS) && w_q)
            wd_q <= {wd_q[23:0], 8'h00};
         if (!w_q && (((state_q == ACCESS) && (k_q != 2'd0)) ||
                      (state_q == DRAIN)))
            asm_q <= {asm_q[23:0], mem_rbyte};
      end
   end

endmodule
